// File: rtl/param_universal_shift_register_pkg.sv
// Shared definitions for the universal shift register: mode codes, FSM states, count width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHL  = 3'd1;
  localparam logic [2:0] MODE_SHR  = 3'd2;
  localparam logic [2:0] MODE_LOAD = 3'd3;
  localparam logic [2:0] MODE_ROTL = 3'd4;
  localparam logic [2:0] MODE_ROTR = 3'd5;
  localparam logic [2:0] MODE_ASR  = 3'd6;
  localparam logic [2:0] MODE_RSVD = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Bits needed to hold a step count from 0 up to and including width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/param_universal_shift_register_step_unit.sv
// Combinational next-value function for one step of any register mode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is registered.
module usr_step_unit
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q_next
);

  // Select the single-step result for the requested mode; reserved acts as hold.
  always_comb begin
    q_next = q;
    case (mode)
      MODE_SHL:  q_next = {q[WIDTH-2:0], ser_in_r};
      MODE_SHR:  q_next = {ser_in_l, q[WIDTH-1:1]};
      MODE_LOAD: q_next = par_in;
      MODE_ROTL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR: q_next = {q[0], q[WIDTH-1:1]};
      MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/param_universal_shift_register.sv
// Parameterised universal shift register with single-step mode and counted multi-step engine.
// Latency: single step lands on the next edge; counted run of N steps ends with done one cycle after edge k+N.
// Backpressure: start/en accepted only while idle; inputs other than ser_in_* ignored while busy.
module param_universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] q_step;
  logic [CNT_W-1:0] cnt_clamped;
  logic             op_static;

  // While running, the latched op drives the step unit; otherwise the live mode does.
  assign step_mode   = (state_q == ST_RUN) ? op_q : mode;
  assign cnt_clamped = (int'(count) > WIDTH) ? CNT_W'(WIDTH) : count;
  // Modes that would do nothing (or the same thing) on every repeated step finish immediately.
  assign op_static   = (mode == MODE_HOLD) || (mode == MODE_LOAD) || (mode == MODE_RSVD);

  usr_step_unit #(
    .WIDTH (WIDTH)
  ) u_step (
    .q        (q_q),
    .mode     (step_mode),
    .ser_in_l (ser_in_l),
    .ser_in_r (ser_in_r),
    .par_in   (par_in),
    .q_next   (q_step)
  );

  // Next-state, counter and register update; done defaults low so it only ever pulses.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    op_d    = op_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = mode;
          rem_d = cnt_clamped;
          if ((cnt_clamped == '0) || op_static) begin
            done_d = 1'b1;
            if (mode == MODE_LOAD) begin
              q_d = q_step;
            end
          end else begin
            state_d = ST_RUN;
          end
        end else if (en) begin
          q_d = q_step;
        end
      end
      ST_RUN: begin
        q_d   = q_step;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low clear that aborts any run.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      op_q    <= MODE_HOLD;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign q         = q_q;
  assign ser_out_l = q_q[WIDTH-1];
  assign ser_out_r = q_q[0];
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Self-checking bench for param_universal_shift_register (WIDTH=8) against an arithmetic model.
// Latency: inputs applied 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpressure: counted runs are waited on with bounded cycle budgets.
module tb_param_universal_shift_register;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clr, en, ser_in_r, ser_in_l, start;
  logic [2:0]    mode;
  logic [W-1:0]  par_in;
  logic [CW-1:0] count;
  logic [W-1:0]  q;
  logic          ser_out_l, ser_out_r, busy, done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  param_universal_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .ser_in_r(ser_in_r), .ser_in_l(ser_in_l),
    .par_in(par_in), .start(start), .count(count), .q(q), .ser_out_l(ser_out_l),
    .ser_out_r(ser_out_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: one step of each mode expressed as byte arithmetic.
  function automatic logic [7:0] ref_step(input logic [7:0] v, input logic [2:0] m,
                                          input logic sl, input logic sr, input logic [7:0] p);
    int x, vi, sli, sri;
    vi = int'(v); sli = sl ? 1 : 0; sri = sr ? 1 : 0;
    case (m)
      3'd1:    x = (vi * 2 + sri) % 256;
      3'd2:    x = vi / 2 + sli * 128;
      3'd3:    x = int'(p);
      3'd4:    x = (vi * 2) % 256 + vi / 128;
      3'd5:    x = vi / 2 + (vi % 2) * 128;
      3'd6:    x = vi / 2 + (vi / 128) * 128;
      default: x = vi;
    endcase
    return x[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; start = 1'b0; mode = 3'd0; count = '0;
    ser_in_l = 1'b0; ser_in_r = 1'b0; par_in = '0;
  endtask

  task automatic load(input logic [7:0] v);
    idle_inputs();
    en = 1'b1; mode = 3'd3; par_in = v;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    clr = 1'b0; en = 1'b1; mode = 3'd3; par_in = 8'hFF;
    tick(); tick();
    total_cnt++;
    if ({q, busy, done} !== {8'h00, 1'b0, 1'b0})
      $display("FAIL reset_state q=%h busy=%b done=%b want q=00 busy=0 done=0", q, busy, done);
    else pass_cnt++;
    clr = 1'b1;
    tick();
    total_cnt++;
    if (q !== 8'hFF) $display("FAIL reset_release q=%h want ff", q);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_single_steps();
    logic [7:0] exp_q;
    logic [2:0] ms [4] = '{3'd1, 3'd2, 3'd5, 3'd6};
    logic [7:0] ws [4] = '{8'h4B, 8'h25, 8'h92, 8'hC9};
    load(8'hA5);
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; mode = ms[i]; ser_in_r = 1'b1; ser_in_l = 1'b0;
      tick();
      total_cnt++;
      if (q !== ws[i]) $display("FAIL single_step_%0d q=%h want %h", i, q, ws[i]);
      else pass_cnt++;
    end
    // Random single steps, including en=0 holds and reserved/hold modes.
    exp_q = q;
    for (int i = 0; i < 30; i++) begin
      en = 1'($urandom_range(0, 3) != 0); mode = 3'($urandom);
      ser_in_l = 1'($urandom); ser_in_r = 1'($urandom); par_in = 8'($urandom);
      if (en) exp_q = ref_step(exp_q, mode, ser_in_l, ser_in_r, par_in);
      tick();
      total_cnt++;
      if ({q, ser_out_l, ser_out_r, busy, done} !== {exp_q, exp_q[7], exp_q[0], 2'b00})
        $display("FAIL rand_step_%0d q=%h so=%b%b busy=%b done=%b want q=%h", i, q,
                 ser_out_l, ser_out_r, busy, done, exp_q);
      else pass_cnt++;
    end
    idle_inputs();
  endtask

  task automatic test_counted_rotate();
    logic [7:0] exp_q;
    load(8'h81);
    start = 1'b1; mode = 3'd4; count = 4'd3;
    tick();
    start = 1'b0; mode = 3'd0;
    total_cnt++;
    if ({q, busy, done} !== {8'h81, 1'b1, 1'b0})
      $display("FAIL rotl_latch q=%h busy=%b done=%b want q=81 busy=1 done=0", q, busy, done);
    else pass_cnt++;
    exp_q = 8'h81;
    for (int s = 1; s <= 3; s++) begin
      exp_q = ref_step(exp_q, 3'd4, 1'b0, 1'b0, 8'h00);
      tick();
      total_cnt++;
      if ({q, busy, done} !== {exp_q, (s < 3), (s == 3)})
        $display("FAIL rotl_step_%0d q=%h busy=%b done=%b want q=%h busy=%b done=%b",
                 s, q, busy, done, exp_q, (s < 3), (s == 3));
      else pass_cnt++;
    end
    total_cnt++;
    if (q !== 8'h0C) $display("FAIL rotl_final q=%h want 0c", q);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL rotl_done_width busy=%b done=%b want 00", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_count_bounds();
    int cyc;
    bit seen;
    load(8'h5A);
    start = 1'b1; mode = 3'd1; count = 4'd0; ser_in_r = 1'b1;
    tick();
    idle_inputs();
    total_cnt++;
    if ({q, busy, done} !== {8'h5A, 1'b0, 1'b1})
      $display("FAIL count0 q=%h busy=%b done=%b want q=5a busy=0 done=1", q, busy, done);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL count0_after busy=%b done=%b want 00", busy, done);
    else pass_cnt++;
    // Counted LOAD completes at once and still loads.
    start = 1'b1; mode = 3'd3; count = 4'd5; par_in = 8'h3C;
    tick();
    idle_inputs();
    total_cnt++;
    if ({q, busy, done} !== {8'h3C, 1'b0, 1'b1})
      $display("FAIL start_load q=%h busy=%b done=%b want q=3c busy=0 done=1", q, busy, done);
    else pass_cnt++;
    load(8'h00);
    start = 1'b1; mode = 3'd2; count = 4'd15; ser_in_l = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      seen = done;
    end
    total_cnt++;
    if (!seen || cyc != W || q !== 8'hFF)
      $display("FAIL count_clamp seen=%0b steps=%0d q=%h want steps=8 q=ff", seen, cyc, q);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit seen;
    load(8'hFF);
    start = 1'b1; mode = 3'd1; count = 4'd6;
    tick();
    idle_inputs();
    tick(); tick();
    total_cnt++;
    if ({q, busy} !== {8'hFC, 1'b1}) $display("FAIL midrun_pre q=%h busy=%b want fc 1", q, busy);
    else pass_cnt++;
    clr = 1'b0;
    tick();
    total_cnt++;
    if ({q, busy, done} !== {8'h00, 1'b0, 1'b0})
      $display("FAIL midrun_reset q=%h busy=%b done=%b want 00 0 0", q, busy, done);
    else pass_cnt++;
    clr = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) seen = 1;
    end
    total_cnt++;
    if (seen) $display("FAIL midrun_no_done activity=1 want 0");
    else pass_cnt++;
    load(8'h03);
    start = 1'b1; mode = 3'd4; count = 4'd2;
    tick();
    start = 1'b0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 10) begin
      tick();
      cyc++;
      seen = done;
    end
    total_cnt++;
    if (!seen || cyc != 2 || q !== 8'h0C)
      $display("FAIL midrun_restart seen=%0b steps=%0d q=%h want steps=2 q=0c", seen, cyc, q);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q;
    logic [2:0] ops [5] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    logic [2:0] op;
    int n, steps;
    load(8'($urandom));
    exp_q = q;
    for (int r = 0; r < 6; r++) begin
      op = ops[$urandom_range(0, 4)];
      n = $urandom_range(1, 15);
      steps = (n > W) ? W : n;
      start = 1'b1; mode = op; count = 4'(n); en = 1'b0;
      tick();
      total_cnt++;
      if ({q, busy, done} !== {exp_q, 1'b1, 1'b0})
        $display("FAIL b2b_latch_%0d q=%h busy=%b done=%b want q=%h busy=1 done=0",
                 r, q, busy, done, exp_q);
      else pass_cnt++;
      for (int s = 1; s <= steps; s++) begin
        mode = 3'($urandom); en = 1'($urandom); start = 1'($urandom);
        count = 4'($urandom); par_in = 8'($urandom);
        ser_in_l = 1'($urandom); ser_in_r = 1'($urandom);
        exp_q = ref_step(exp_q, op, ser_in_l, ser_in_r, par_in);
        tick();
        total_cnt++;
        if ({q, busy, done} !== {exp_q, (s < steps), (s == steps)})
          $display("FAIL b2b_run_%0d_%0d q=%h busy=%b done=%b want q=%h busy=%b done=%b",
                   r, s, q, busy, done, exp_q, (s < steps), (s == steps));
        else pass_cnt++;
      end
    end
    idle_inputs();
    tick();
    total_cnt++;
    if ({q, busy, done} !== {exp_q, 2'b00})
      $display("FAIL b2b_tail q=%h busy=%b done=%b want q=%h 0 0", q, busy, done, exp_q);
    else pass_cnt++;
  endtask

  initial begin
    clr = 1'b0;
    idle_inputs();
    test_reset();
    test_single_steps();
    test_counted_rotate();
    test_count_bounds();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
